// File: rtl/stack_address_sequencer_if.sv
// Bundle between the control unit / data-memory port and stack_address_sequencer.
// Request side: start, op, M, base_address, beats.
// Memory side:  mem_ready in; addr_valid, addr, beat_index, last out.
// Status side:  busy, done, overflow, underflow, user_sp, priv_sp.
// master = control unit / memory model, slave = the sequencer.
interface stack_address_sequencer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [1:0]            op;
    logic                  M;
    logic [31:0]           base_address;
    logic [2:0]            beats;
    logic                  mem_ready;
    logic                  busy;
    logic                  addr_valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            beat_index;
    logic                  last;
    logic                  done;
    logic                  overflow;
    logic                  underflow;
    logic [31:0]           user_sp;
    logic [31:0]           priv_sp;

    modport master (
        output start, op, M, base_address, beats, mem_ready,
        input  busy, addr_valid, addr, beat_index, last, done,
               overflow, underflow, user_sp, priv_sp
    );

    modport slave (
        input  start, op, M, base_address, beats, mem_ready,
        output busy, addr_valid, addr, beat_index, last, done,
               overflow, underflow, user_sp, priv_sp
    );
endinterface

// File: rtl/stack_address_sequencer.sv
// stack_address_sequencer: owns the banked user/privileged stack pointers and
// issues one byte address per beat under a valid/ready handshake for PUSH, POP
// and plain burst load/store requests.
// Ports: clock (rising edge), reset (async, active-high), bus (slave modport of
// stack_address_sequencer_if carrying request, beat stream and status).
module stack_address_sequencer #(
    parameter int ADDR_WIDTH       = 10,
    parameter int MAX_BEATS        = 4,
    parameter int USER_STACK_START = 31,
    parameter int USER_STACK_END   = 36,
    parameter int PRIV_STACK_START = 37,
    parameter int PRIV_STACK_END   = 42
) (
    input  logic                        clock,
    input  logic                        reset,
    stack_address_sequencer_if.slave    bus
);
    localparam logic [31:0] SP_EMPTY = 32'hFFFF_FFFF;
    localparam logic [31:0] U_LO     = 32'(USER_STACK_START);
    localparam logic [31:0] U_HI     = 32'(USER_STACK_END);
    localparam logic [31:0] P_LO     = 32'(PRIV_STACK_START);
    localparam logic [31:0] P_HI     = 32'(PRIV_STACK_END);
    localparam logic [1:0]  OP_NONE  = 2'd0;
    localparam logic [1:0]  OP_PUSH  = 2'd1;
    localparam logic [1:0]  OP_POP   = 2'd2;
    localparam logic [1:0]  OP_BURST = 2'd3;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    state_t                state_r, state_s;
    logic [1:0]            op_r;
    logic                  m_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [2:0]            n_r;
    logic [2:0]            beat_r;
    logic [31:0]           user_sp_r, priv_sp_r;
    logic                  overflow_r, underflow_r;

    logic                  accept_s;
    logic [31:0]           sp_s, lo_s, hi_s, sp_dec_s, sp_inc_s, sp_next_s;
    logic [ADDR_WIDTH-1:0] beat_addr_s;
    logic                  beat_err_s, beat_ok_s, beat_fire_s, beat_last_s;
    logic                  unused_base_s;

    // Only the low ADDR_WIDTH bits of the burst top address are meaningful.
    assign unused_base_s = ^bus.base_address[31:ADDR_WIDTH];

    // Beat count 0 means one beat; oversized counts saturate at MAX_BEATS.
    function automatic logic [2:0] clamp_beats(input logic [2:0] b);
        logic [2:0] r;
        if (b == 3'd0) begin
            r = 3'd1;
        end else if ({1'b0, b} > 4'(MAX_BEATS)) begin
            r = 3'(MAX_BEATS);
        end else begin
            r = b;
        end
        return r;
    endfunction

    assign accept_s = (state_r == ST_IDLE) && bus.start && (bus.op != OP_NONE);

    // Per-beat address, error check and successor SP for the active bank.
    always_comb begin
        sp_s        = m_r ? priv_sp_r : user_sp_r;
        lo_s        = m_r ? P_LO : U_LO;
        hi_s        = m_r ? P_HI : U_HI;
        sp_dec_s    = sp_s - 32'd1;
        sp_inc_s    = sp_s + 32'd1;
        sp_next_s   = sp_s;
        beat_addr_s = {ADDR_WIDTH{1'b0}};
        beat_err_s  = 1'b0;
        case (op_r)
            OP_PUSH: begin
                if (sp_s == SP_EMPTY) begin
                    sp_next_s   = hi_s;
                    beat_addr_s = hi_s[ADDR_WIDTH-1:0];
                end else if ((sp_s > lo_s) && (sp_s <= hi_s)) begin
                    sp_next_s   = sp_dec_s;
                    beat_addr_s = sp_dec_s[ADDR_WIDTH-1:0];
                end else begin
                    beat_err_s  = 1'b1;
                end
            end
            OP_POP: begin
                if ((sp_s >= lo_s) && (sp_s < hi_s)) begin
                    sp_next_s   = sp_inc_s;
                    beat_addr_s = sp_s[ADDR_WIDTH-1:0];
                end else if (sp_s == hi_s) begin
                    sp_next_s   = SP_EMPTY;
                    beat_addr_s = hi_s[ADDR_WIDTH-1:0];
                end else begin
                    beat_err_s  = 1'b1;
                end
            end
            OP_BURST: begin
                // Ascending run ending on base: base - (N-1) + i, wrapping.
                beat_addr_s = base_r
                            + {{(ADDR_WIDTH-3){1'b0}}, beat_r}
                            - {{(ADDR_WIDTH-3){1'b0}}, n_r - 3'd1};
            end
            default: begin
                beat_err_s  = 1'b0;
            end
        endcase
    end

    assign beat_ok_s   = (state_r == ST_RUN) && !beat_err_s;
    assign beat_fire_s = beat_ok_s && bus.mem_ready;
    assign beat_last_s = (beat_r == (n_r - 3'd1));

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((state_r == ST_RUN) && beat_err_s) begin
                    state_s = ST_DONE;
                end else if (beat_fire_s && beat_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request latch, beat counter, stack pointers and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_r        <= OP_NONE;
            m_r         <= 1'b0;
            base_r      <= {ADDR_WIDTH{1'b0}};
            n_r         <= 3'd1;
            beat_r      <= 3'd0;
            user_sp_r   <= SP_EMPTY;
            priv_sp_r   <= SP_EMPTY;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (accept_s) begin
            op_r        <= bus.op;
            m_r         <= bus.M;
            base_r      <= bus.base_address[ADDR_WIDTH-1:0];
            n_r         <= clamp_beats(bus.beats);
            beat_r      <= 3'd0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            if (beat_err_s) begin
                overflow_r  <= overflow_r  | (op_r == OP_PUSH);
                underflow_r <= underflow_r | (op_r == OP_POP);
            end else if (beat_fire_s) begin
                if (!beat_last_s) begin
                    beat_r <= beat_r + 3'd1;
                end
                // Only the bank selected at acceptance moves; bursts leave both alone.
                if ((op_r != OP_BURST) && m_r) begin
                    priv_sp_r <= sp_next_s;
                end else if (op_r != OP_BURST) begin
                    user_sp_r <= sp_next_s;
                end
            end
        end
    end

    // FSM output decode.
    always_comb begin
        bus.busy      = (state_r != ST_IDLE);
        bus.done      = (state_r == ST_DONE);
        bus.overflow  = overflow_r;
        bus.underflow = underflow_r;
        bus.user_sp   = user_sp_r;
        bus.priv_sp   = priv_sp_r;
        if (beat_ok_s) begin
            bus.addr_valid = 1'b1;
            bus.addr       = beat_addr_s;
            bus.beat_index = beat_r;
            bus.last       = beat_last_s;
        end else begin
            bus.addr_valid = 1'b0;
            bus.addr       = {ADDR_WIDTH{1'b0}};
            bus.beat_index = 3'd0;
            bus.last       = 1'b0;
        end
    end
endmodule

// File: doc/stack_address_sequencer.md
# stack_address_sequencer

Sequential, parametrised successor to the combinational memory address handler. It owns the banked user/privileged stack pointers and issues one memory byte address per beat under a valid/ready handshake, so multi-byte PUSH/POP bursts and multi-byte load/store bursts run as registered sequences. It sits between the control unit (op request) and the data-memory port (address stream).

## Interface
- ADDR_WIDTH, 10, width of the issued byte address
- MAX_BEATS, 4, maximum beats per request (2..8)
- USER_STACK_START, 31, lowest user stack address
- USER_STACK_END, 36, highest user stack address (first push target)
- PRIV_STACK_START, 37, lowest privileged stack address
- PRIV_STACK_END, 42, highest privileged stack address
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request strobe, sampled only when busy=0
- op  in  2  0 none, 1 PUSH, 2 POP, 3 burst load/store
- M  in  1  0 user stack, 1 privileged stack (sampled with start)
- base_address  in  32  burst top address for op 3 (low ADDR_WIDTH bits used)
- beats  in  3  beat count; 0 treated as 1, >MAX_BEATS clamped
- mem_ready  in  1  memory accepts current beat
- busy  out  1  request in progress
- addr_valid  out  1  addr is a live beat
- addr  out  ADDR_WIDTH  beat byte address
- beat_index  out  3  index of current beat, 0-based
- last  out  1  current beat is final beat
- done  out  1  one-cycle completion pulse
- overflow  out  1  push found stack full; held until next accepted start
- underflow  out  1  pop found stack empty; held until next accepted start
- user_sp  out  32  user stack pointer; 32'hFFFFFFFF = empty
- priv_sp  out  32  privileged stack pointer; 32'hFFFFFFFF = empty

## Operation
- FSM states: IDLE, RUN, DONE. IDLE->RUN on start=1 with op!=0 and busy=0; op=0 start is ignored.
- Request fields (op, M, base_address, clamped beats) are latched at acceptance; later input changes have no effect.
- RUN: addr_valid=1, busy=1. A beat completes on a cycle with addr_valid=1 and mem_ready=1. After the last beat completes, or on an error, the FSM goes to DONE.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE.
- Active SP (selected by latched M) is governed by the bank bounds S=START and E=END.
- PUSH beat:
  - SP empty: addr=E, SP<=E.
  - S<SP<=E: addr=SP-1, SP<=SP-1.
  - Otherwise (full): no beat issued, overflow<=1, abort to DONE.
- POP beat:
  - S<=SP<E: addr=SP, SP<=SP+1.
  - SP==E: addr=E, SP<=empty.
  - Otherwise (empty): no beat, underflow<=1, abort to DONE.
- Error check is evaluated combinationally on the current SP at the start of each beat. An overflow or underflow mid-burst keeps the beats already completed, and addr_valid never rises for the failing beat.
- Op 3: beat i address = base - (N-1) + i, where N is the clamped beat count, so the last beat addresses base. Arithmetic is modulo 2^ADDR_WIDTH (wraps). SPs are not touched.
- Each SP updates only on its own beat completion. The inactive bank never changes.
- last = (beat_index == N-1) while addr_valid=1.
- Outside RUN: addr=0, addr_valid=0, last=0, beat_index=0.

## Timing
- Reset (asynchronous, any state, including mid-burst):
  - FSM to IDLE.
  - user_sp and priv_sp to 32'hFFFFFFFF.
  - overflow and underflow to 0.
  - busy, addr_valid, done, last to 0; addr and beat_index to 0.
  - A partially completed burst is abandoned.
- Start accepted at edge k: busy=1 and addr_valid=1 from cycle k+1. Flags clear at edge k.
- A beat completing at edge j: SP and beat_index update at j. The next beat's addr is valid in cycle j+1 (zero bubbles).
- With mem_ready held high, an N-beat request occupies N cycles of RUN plus 1 cycle of DONE. Next start is accepted at the DONE->IDLE edge + 1 at earliest.
- mem_ready low stalls: addr, beat_index, last, and SP stay stable.
- start asserted while busy=1 is ignored, and is not queued.

## Test plan
- Reset, then PUSH M=0 beats=1, mem_ready=1 -> addr=36, user_sp=36, done pulse 2 cycles after start, priv_sp=FFFFFFFF.
- From user_sp=36, PUSH beats=8 (clamped to 4) -> addrs 35,34,33,32, user_sp=32.
- Next PUSH beats=2 -> addr 31, user_sp=31, then overflow=1, no second beat, done pulse.
- POP M=1 on empty bank -> addr_valid never rises, underflow=1, priv_sp=FFFFFFFF.
- PUSH M=1 beats=2 -> addrs 42,41. Then POP beats=2 with mem_ready toggling 1,0,1 -> addrs 41 (held through stall), 42, priv_sp=FFFFFFFF.
- Op 3 base=1, beats=4 -> addrs 0x3FE,0x3FF,0x000,0x001 (wrap), last on beat 3. Assert reset during beat 2 -> all outputs at reset values in the same cycle.
